// File: rtl/csr_unit.sv
// Machine/supervisor CSR file and privilege-mode controller for the RV32I core.
// Combinational CSR read/legality check, registered state updates and trap/return redirect.
module csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL  = 32'h4014_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [1:0]  priv_ret,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        retire_valid,
  output logic [31:0] csr_rdata,
  output logic        illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  priv_mode
);

  localparam logic [1:0]  PRIV_U = 2'b00;
  localparam logic [1:0]  PRIV_M = 2'b11;
  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;

  logic [1:0]  priv;
  logic        sie, mie, spie, mpie, spp;
  logic [1:0]  mpp;
  logic [31:0] mtvec, mepc, mcause, mscratch;
  logic [31:0] stvec, sepc, scause, sscratch;
  logic [63:0] mcycle, minstret;
  logic [63:0] cycle_nxt, instret_nxt;
  logic [31:0] mstatus_val, rd_val, wval;
  logic        addr_ok, csr_active, csr_write, csr_illegal;
  logic        ret_active, ret_illegal, do_csr, do_mret, do_sret;

  assign priv_mode   = priv;
  assign mstatus_val = {19'b0, mpp, 2'b0, spp, mpie, 1'b0, spie, 1'b0, mie, 1'b0, sie, 1'b0};

  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      12'h100: rd_val = mstatus_val & SSTATUS_MASK;
      12'h105: rd_val = stvec;
      12'h140: rd_val = sscratch;
      12'h141: rd_val = sepc;
      12'h142: rd_val = scause;
      12'h300: rd_val = mstatus_val;
      12'h301: rd_val = MISA_VAL;
      12'h305: rd_val = mtvec;
      12'h340: rd_val = mscratch;
      12'h341: rd_val = mepc;
      12'h342: rd_val = mcause;
      12'hB00: rd_val = mcycle[31:0];
      12'hB02: rd_val = minstret[31:0];
      12'hB80: rd_val = mcycle[63:32];
      12'hB82: rd_val = minstret[63:32];
      12'hF14: rd_val = '0;
      default: addr_ok = 1'b0;
    endcase
  end

  // csrrs with a zero mask is a pure read, so it may touch read-only space
  assign csr_active  = (csr_op == 2'b01) || (csr_op == 2'b10);
  assign csr_write   = (csr_op == 2'b01) || ((csr_op == 2'b10) && (csr_wdata != '0));
  assign csr_illegal = csr_active && (!addr_ok || (priv < csr_addr[9:8]) ||
                                      ((csr_addr[11:10] == 2'b11) && csr_write));
  assign ret_active  = (priv_ret == 2'b01) || (priv_ret == 2'b10);
  assign ret_illegal = ((priv_ret == 2'b01) && (priv != PRIV_M)) ||
                       ((priv_ret == 2'b10) && (priv == PRIV_U));

  assign illegal   = ret_active ? ret_illegal : csr_illegal;
  assign csr_rdata = csr_illegal ? '0 : rd_val;
  assign wval      = (csr_op == 2'b01) ? csr_wdata : (rd_val | csr_wdata);

  assign do_mret = !exc_valid && (priv_ret == 2'b01) && !ret_illegal;
  assign do_sret = !exc_valid && (priv_ret == 2'b10) && !ret_illegal;
  assign do_csr  = !exc_valid && !ret_active && csr_write && !csr_illegal;

  // a write to either half replaces the increment for the full 64-bit counter
  always_comb begin
    cycle_nxt   = mcycle + 64'd1;
    instret_nxt = minstret + {63'b0, retire_valid};
    if (do_csr) begin
      case (csr_addr)
        12'hB00: cycle_nxt   = {mcycle[63:32], wval};
        12'hB80: cycle_nxt   = {wval, mcycle[31:0]};
        12'hB02: instret_nxt = {minstret[63:32], wval};
        12'hB82: instret_nxt = {wval, minstret[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      priv           <= PRIV_M;
      {sie, mie, spie, mpie, spp} <= '0;
      mpp            <= '0;
      mtvec          <= MTVEC_RST;
      mepc           <= '0;
      mcause         <= '0;
      mscratch       <= '0;
      stvec          <= '0;
      sepc           <= '0;
      scause         <= '0;
      sscratch       <= '0;
      mcycle         <= '0;
      minstret       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mcycle         <= cycle_nxt;
      minstret       <= instret_nxt;
      redirect_valid <= 1'b0;
      if (exc_valid) begin
        mepc           <= exc_pc & ~32'h3;
        mcause         <= {28'b0, exc_cause};
        mpie           <= mie;
        mie            <= 1'b0;
        mpp            <= priv;
        priv           <= PRIV_M;
        redirect_valid <= 1'b1;
        redirect_pc    <= {mtvec[31:2], 2'b00};
      end else if (do_mret) begin
        priv           <= mpp;
        mie            <= mpie;
        mpie           <= 1'b1;
        mpp            <= PRIV_U;
        redirect_valid <= 1'b1;
        redirect_pc    <= mepc;
      end else if (do_sret) begin
        priv           <= {1'b0, spp};
        sie            <= spie;
        spie           <= 1'b1;
        spp            <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= sepc;
      end else if (do_csr) begin
        case (csr_addr)
          12'h100: begin
            sie  <= wval[1];
            spie <= wval[5];
            spp  <= wval[8];
          end
          12'h105: stvec    <= wval & ~32'h3;
          12'h140: sscratch <= wval;
          12'h141: sepc     <= wval & ~32'h3;
          12'h142: scause   <= wval;
          12'h300: begin
            sie  <= wval[1];
            mie  <= wval[3];
            spie <= wval[5];
            mpie <= wval[7];
            spp  <= wval[8];
            if (wval[12:11] != 2'b10) mpp <= wval[12:11];
          end
          12'h305: mtvec    <= wval & ~32'h3;
          12'h340: mscratch <= wval;
          12'h341: mepc     <= wval & ~32'h3;
          12'h342: mcause   <= wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: reset, CSR access rules, traps,
// returns, event priority and counters, with hand-computed expectations.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  priv_ret;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        retire_valid;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_mode;

  int vectors = 0;
  int miscompares = 0;

  csr_unit dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .priv_ret(priv_ret), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .retire_valid(retire_valid), .csr_rdata(csr_rdata), .illegal(illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv_mode(priv_mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_op = 2'b00; csr_addr = '0; csr_wdata = '0; priv_ret = 2'b00;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; retire_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    idle();
    csr_op = 2'b10; csr_addr = a; csr_wdata = '0;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_op = 2'b01; csr_addr = a; csr_wdata = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h0000_0800;
    step();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_redirect: got %b want 0", redirect_valid); end
    vectors++; if (priv_mode !== 2'b11) begin miscompares++; $display("FAIL rst_priv: got %b want 11", priv_mode); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(12'hB00);
      vectors++; if (csr_rdata !== 32'(i)) begin miscompares++; $display("FAIL mcycle_count%0d: got %h want %h", i, csr_rdata, 32'(i)); end
      step();
    end
    rd(12'h301);
    vectors++; if (csr_rdata !== 32'h4014_0100 || illegal !== 1'b0) begin miscompares++; $display("FAIL misa_read: got %h/%b want 40140100/0", csr_rdata, illegal); end
    step();
    rd(12'h305);
    vectors++; if (csr_rdata !== 32'h0000_0100) begin miscompares++; $display("FAIL mtvec_rst: got %h want 00000100", csr_rdata); end
    step();
    rd(12'h300);
    vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mstatus_rst: got %h want 0", csr_rdata); end
    step();
    rd(12'h341);
    vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mepc_rst: got %h want 0", csr_rdata); end
    step();
  endtask

  task automatic test_scratch();
    wr(12'h340, 32'hDEAD_BEEF);
    vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mscratch_old: got %h want 0", csr_rdata); end
    step();
    idle(); csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 32'h1; #1;
    vectors++; if (csr_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mscratch_rs: got %h want deadbeef", csr_rdata); end
    step();
    rd(12'h340);
    vectors++; if (csr_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mscratch_reread: got %h want deadbeef", csr_rdata); end
    step();
    wr(12'h341, 32'h0000_1237);
    step();
    rd(12'h341);
    vectors++; if (csr_rdata !== 32'h0000_1234) begin miscompares++; $display("FAIL mepc_align: got %h want 00001234", csr_rdata); end
    step();
    wr(12'hF14, 32'h5);
    vectors++; if (illegal !== 1'b1 || csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mhartid_write: got %b/%h want 1/0", illegal, csr_rdata); end
    step();
    rd(12'hF14);
    vectors++; if (illegal !== 1'b0 || csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mhartid_read: got %b/%h want 0/0", illegal, csr_rdata); end
    step();
    wr(12'h7C0, 32'h1);
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL unknown_addr: got %b want 1", illegal); end
    step();
  endtask

  task automatic test_mstatus();
    wr(12'h300, 32'h0000_1008);
    step();
    rd(12'h300);
    vectors++; if (csr_rdata !== 32'h0000_0008) begin miscompares++; $display("FAIL mstatus_mpp10: got %h want 00000008", csr_rdata); end
    step();
  endtask

  task automatic test_trap();
    idle(); exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h0000_2006;
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL trap_redirect: got %b/%h want 1/00000100", redirect_valid, redirect_pc); end
    rd(12'h341);
    vectors++; if (csr_rdata !== 32'h0000_2004) begin miscompares++; $display("FAIL trap_mepc: got %h want 00002004", csr_rdata); end
    step();
    vectors++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL trap_pulse: got %b/%h want 0/00000100", redirect_valid, redirect_pc); end
    rd(12'h342);
    vectors++; if (csr_rdata !== 32'd11) begin miscompares++; $display("FAIL trap_mcause: got %h want 0000000b", csr_rdata); end
    step();
    rd(12'h300);
    vectors++; if (csr_rdata !== 32'h0000_1880) begin miscompares++; $display("FAIL trap_mstatus: got %h want 00001880", csr_rdata); end
    step();
  endtask

  task automatic test_mret_user();
    wr(12'h300, 32'h0000_0080);
    step();
    wr(12'h341, 32'h0000_3000);
    step();
    idle(); priv_ret = 2'b01; #1;
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL mret_legal: got %b want 0", illegal); end
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000 || priv_mode !== 2'b00) begin miscompares++; $display("FAIL mret_redirect: got %b/%h/%b want 1/00003000/00", redirect_valid, redirect_pc, priv_mode); end
    rd(12'h300);
    vectors++; if (illegal !== 1'b1 || csr_rdata !== 32'h0) begin miscompares++; $display("FAIL user_mstatus: got %b/%h want 1/0", illegal, csr_rdata); end
    step();
    wr(12'h300, 32'h0000_FFFF);
    step();
    idle(); priv_ret = 2'b01; #1;
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL user_mret: got %b want 1", illegal); end
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b0 || priv_mode !== 2'b00) begin miscompares++; $display("FAIL user_mret_drop: got %b/%b want 0/00", redirect_valid, priv_mode); end
    exc_valid = 1'b1; exc_cause = 4'd8; exc_pc = 32'h0000_3004;
    step();
    idle();
    vectors++; if (priv_mode !== 2'b11 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL ecall_u: got %b/%h want 11/00000100", priv_mode, redirect_pc); end
    rd(12'h300);
    vectors++; if (csr_rdata !== 32'h0000_0080) begin miscompares++; $display("FAIL ecall_u_mstatus: got %h want 00000080", csr_rdata); end
    step();
    rd(12'h342);
    vectors++; if (csr_rdata !== 32'd8) begin miscompares++; $display("FAIL ecall_u_mcause: got %h want 00000008", csr_rdata); end
    step();
  endtask

  task automatic test_sret();
    wr(12'h300, 32'h0000_0800);
    step();
    wr(12'h341, 32'h0000_4000);
    step();
    wr(12'h141, 32'h0000_5002);
    step();
    idle(); priv_ret = 2'b01;
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4000 || priv_mode !== 2'b01) begin miscompares++; $display("FAIL mret_to_s: got %b/%h/%b want 1/00004000/01", redirect_valid, redirect_pc, priv_mode); end
    rd(12'h340);
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL s_mscratch: got %b want 1", illegal); end
    step();
    rd(12'h141);
    vectors++; if (illegal !== 1'b0 || csr_rdata !== 32'h5000) begin miscompares++; $display("FAIL s_sepc: got %b/%h want 0/00005000", illegal, csr_rdata); end
    step();
    wr(12'h100, 32'h0000_0122);
    step();
    rd(12'h100);
    vectors++; if (csr_rdata !== 32'h0000_0122) begin miscompares++; $display("FAIL sstatus_view: got %h want 00000122", csr_rdata); end
    step();
    idle(); priv_ret = 2'b01; #1;
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL s_mret: got %b want 1", illegal); end
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL s_mret_drop: got %b want 0", redirect_valid); end
    priv_ret = 2'b10; #1;
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL sret_legal: got %b want 0", illegal); end
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h5000 || priv_mode !== 2'b01) begin miscompares++; $display("FAIL sret_redirect: got %b/%h/%b want 1/00005000/01", redirect_valid, redirect_pc, priv_mode); end
    rd(12'h100);
    vectors++; if (csr_rdata !== 32'h0000_0022) begin miscompares++; $display("FAIL sret_sstatus: got %h want 00000022", csr_rdata); end
    step();
    idle(); exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h0000_5000;
    step();
    idle();
    vectors++; if (priv_mode !== 2'b11 || redirect_valid !== 1'b1) begin miscompares++; $display("FAIL trap_from_s: got %b/%b want 11/1", priv_mode, redirect_valid); end
  endtask

  task automatic test_priority();
    idle();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h0000_6000;
    priv_ret = 2'b01;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL prio_redirect: got %b/%h want 1/00000100", redirect_valid, redirect_pc); end
    rd(12'h341);
    vectors++; if (csr_rdata !== 32'h6000) begin miscompares++; $display("FAIL prio_mepc: got %h want 00006000", csr_rdata); end
    step();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL prio_single: got %b want 0", redirect_valid); end
    rd(12'h340);
    vectors++; if (csr_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL prio_mscratch: got %h want deadbeef", csr_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    idle(); exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h0000_7000;
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL b2b_trap: got %b/%h want 1/00000100", redirect_valid, redirect_pc); end
    priv_ret = 2'b01;
    step();
    idle();
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h7000 || priv_mode !== 2'b11) begin miscompares++; $display("FAIL b2b_mret: got %b/%h/%b want 1/00007000/11", redirect_valid, redirect_pc, priv_mode); end
    step();
    vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", redirect_valid); end
  endtask

  task automatic test_counters();
    wr(12'hB00, 32'hFFFF_FFFF);
    step();
    rd(12'hB00);
    vectors++; if (csr_rdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mcycle_wr: got %h want ffffffff", csr_rdata); end
    step();
    rd(12'hB00);
    vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mcycle_wrap: got %h want 0", csr_rdata); end
    step();
    rd(12'hB80);
    vectors++; if (csr_rdata !== 32'h1) begin miscompares++; $display("FAIL mcycleh_carry: got %h want 1", csr_rdata); end
    step();
    wr(12'hB02, 32'h5); retire_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      rd(12'hB02); retire_valid = (i < 2);
      vectors++; if (csr_rdata !== 32'(5 + i)) begin miscompares++; $display("FAIL minstret%0d: got %h want %h", i, csr_rdata, 32'(5 + i)); end
      step();
    end
    rd(12'hB02);
    vectors++; if (csr_rdata !== 32'h7) begin miscompares++; $display("FAIL minstret_hold: got %h want 7", csr_rdata); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_scratch();
    test_mstatus();
    test_trap();
    test_mret_user();
    test_sret();
    test_priority();
    test_back_to_back();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine/supervisor CSR file and privilege-mode controller for the RV32I five-stage core. Sits beside the EX stage and services the CSR operation, CSR address and privileged-return codes the decode stage produces (csr_op 00/01/10, priv_ret 00/01/10). It also takes synchronous exceptions from the pipeline and returns a registered PC redirect for trap entry, mret and sret. It owns the 64-bit cycle and instret counters.

## Interface
- MTVEC_RST, 32'h0000_0100: reset value of mtvec.
- MISA_VAL, 32'h4014_0100: constant misa (RV32, I, S, U).
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- csr_op  in  2  00 none, 01 csrrw, 10 csrrs (11 treated as none).
- csr_addr  in  12  CSR address of the EX-stage instruction.
- csr_wdata  in  32  rs1 value (write data or set mask).
- priv_ret  in  2  00 none, 01 mret, 10 sret.
- exc_valid  in  1  synchronous exception in EX this cycle.
- exc_cause  in  4  exception code (e.g. 2 illegal, 8 ecall-U, 11 ecall-M).
- exc_pc  in  32  PC of the faulting instruction.
- retire_valid  in  1  one instruction retires this cycle.
- csr_rdata  out  32  old CSR value (combinational), 0 when illegal.
- illegal  out  1  CSR access or return not permitted (combinational).
- redirect_valid  out  1  registered one-cycle redirect pulse.
- redirect_pc  out  32  registered redirect target.
- priv_mode  out  2  current privilege: 00 U, 01 S, 11 M.

## Operation
- Implemented CSRs: sstatus 0x100, stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142, mstatus 0x300, misa 0x301 (RO), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 (RO, 0). Any other address is illegal.
- mstatus writable bits: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. Other bits read 0. A write of MPP=2'b10 keeps the old MPP. sstatus is a view of mstatus with mask bits 1, 5 and 8.
- mepc/sepc: bits [1:0] forced to 0. mtvec/stvec: direct mode only, bits [1:0] read 0.
- csrrw writes csr_wdata. csrrs writes old|csr_wdata.
- An access is illegal in either of these cases:
  - priv_mode < csr_addr[9:8].
  - csr_addr[11:10]==2'b11 and the op is a write. csrrs with csr_wdata==0 counts as a read, not a write.
- mret is illegal unless priv_mode==M. sret is illegal in U.
- Illegal operations change no state, give illegal=1 and csr_rdata=0. The pipeline raises the exception in a later cycle.
- Trap entry (exc_valid) does the following:
  - mepc ← exc_pc&~3, mcause ← {28'b0,exc_cause}.
  - MPIE ← MIE, MIE ← 0, MPP ← priv_mode, priv_mode ← M.
  - Redirect to {mtvec[31:2],2'b00}.
  - No delegation and no interrupts.
- mret: priv_mode ← MPP, MIE ← MPIE, MPIE ← 1, MPP ← 00. Redirect to mepc.
- sret: priv_mode ← {1'b0,SPP}, SIE ← SPIE, SPIE ← 1, SPP ← 0. Redirect to sepc.
- Priority, highest first: exc_valid, then priv_ret, then csr_op. A lower-priority event in the same cycle is dropped entirely: no write, no redirect.
- Counters:
  - mcycle increments every cycle. minstret increments when retire_valid=1.
  - Both are 64-bit with carry from low word to high word.
  - A CSR write to any counter half in the same cycle wins over the increment for the whole 64-bit counter.

## Timing
- csr_rdata, illegal: combinational from current state and inputs. This gives a zero-latency read for EX/MEM.
- CSR writes, trap/return state updates and counter updates all land at the rising edge that ends the cycle.
- redirect_valid is high for exactly one cycle, the cycle after the trap, mret or sret. redirect_pc is valid with it and holds its value otherwise.
- Back-to-back events on consecutive cycles are each honoured. Each one's redirect follows one cycle later.
- Reset values:
  - priv_mode=11.
  - mstatus, mepc, mcause, mscratch, sepc, scause, sscratch, stvec, all counters = 0.
  - mtvec=MTVEC_RST.
  - redirect_valid=0, redirect_pc=0.
- rst asserted together with any event: reset wins and no redirect is produced.
- mcycle reads 0 in the first cycle after reset and 1 in the second.

## Test plan
- Reset, then csrrs 0x301 with wdata 0: csr_rdata=0x4014_0100, illegal=0. mtvec reads 0x100. mcycle counts 0,1,2 on successive cycles.
- csrrw 0x340 ← 0xDEAD_BEEF, then csrrs 0x340 with 0x1: reads 0xDEAD_BEEF, then the next read returns 0xDEAD_BEEF.
- mstatus ← 0x0000_0008, then exc_valid with cause 11, pc 0x0000_2006:
  - Next cycle redirect_valid=1, redirect_pc=0x100.
  - mepc=0x2004, mcause=11, mstatus=0x0000_1880.
- mstatus MPP=00, mepc=0x3000, then mret: redirect_pc=0x3000, priv_mode=00. A following csrrs 0x300 gives illegal=1, rdata=0, and mstatus is unchanged.
- exc_valid, priv_ret=01 and csrrw 0x340 all in one cycle: only the trap takes effect. mscratch is unchanged and there is a single redirect to mtvec.
- mcycle low word ← 0xFFFF_FFFF: two cycles later mcycleh=1 and mcycle=0x0000_0000. With retire_valid held high, minstret advances by one per cycle.
